lfsr_checker: RTL

- Consumes the 4-bit LFSR sample stream produced by the day-7 LFSR stage, sitting directly downstream of it.
- Self-synchronises to the stream by predicting each next value from the previous sample, then declares lock.
- Flags, counts and reports errors, and detects the all-zero lock-up state.
- Used as the on-chip checker for the PRBS path.

---
 rtl/lfsr_checker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lfsr_checker.sv
// PRBS stream checker: self-synchronises to a Fibonacci LFSR sample stream,
// tracks lock, and reports/counts mismatches and all-zero lock-up samples.
module lfsr_checker #(
    parameter int unsigned           WIDTH      = 4,
    parameter logic [WIDTH-1:0]      TAPS       = 4'b1100,
    parameter int unsigned           LOCK_CNT   = 4,
    parameter int unsigned           ERR_THRESH = 3,
    parameter int unsigned           CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] lfsr_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             zero_o
);

    localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(ERR_THRESH + 1);

    typedef enum logic [0:0] {
        SEEK   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               has_prev_q, has_prev_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               zero_q, zero_d;

    logic               is_zero_s;
    logic               match_s;
    logic [RUN_W-1:0]   run_inc_s;
    logic [MISS_W-1:0]  miss_inc_s;
    logic [CNT_W-1:0]   cnt_sat_s;
    logic [CNT_W-1:0]   cnt_nxt_s;

    // A zero sample never matches, so a stuck-at-zero source can never hold lock.
    assign is_zero_s  = (lfsr_i == {WIDTH{1'b0}});
    assign match_s    = has_prev_q && (lfsr_i == lfsr_next(prev_q)) && !is_zero_s;
    assign run_inc_s  = run_cnt_q + {{(RUN_W-1){1'b0}}, 1'b1};
    assign miss_inc_s = miss_cnt_q + {{(MISS_W-1){1'b0}}, 1'b1};
    assign cnt_sat_s  = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q
                                                     : err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state: lock FSM, error pulse/counter and sticky zero flag.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        has_prev_d = has_prev_q;
        run_cnt_d  = run_cnt_q;
        miss_cnt_d = miss_cnt_q;
        err_d      = 1'b0;
        cnt_nxt_s  = err_cnt_q;

        if (valid_i) begin
            prev_d     = lfsr_i;
            has_prev_d = 1'b1;
            case (state_q)
                SEEK: begin
                    if (match_s && (run_inc_s == RUN_W'(LOCK_CNT))) begin
                        state_d    = LOCKED;
                        run_cnt_d  = {RUN_W{1'b0}};
                        miss_cnt_d = {MISS_W{1'b0}};
                    end else if (match_s) begin
                        run_cnt_d = run_inc_s;
                    end else begin
                        run_cnt_d = {RUN_W{1'b0}};
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        miss_cnt_d = {MISS_W{1'b0}};
                    end else if (miss_inc_s == MISS_W'(ERR_THRESH)) begin
                        err_d      = 1'b1;
                        cnt_nxt_s  = cnt_sat_s;
                        state_d    = SEEK;
                        run_cnt_d  = {RUN_W{1'b0}};
                        miss_cnt_d = {MISS_W{1'b0}};
                    end else begin
                        err_d      = 1'b1;
                        cnt_nxt_s  = cnt_sat_s;
                        miss_cnt_d = miss_inc_s;
                    end
                end
                default: begin
                    state_d    = SEEK;
                    run_cnt_d  = {RUN_W{1'b0}};
                    miss_cnt_d = {MISS_W{1'b0}};
                end
            endcase
        end else begin
            err_d = 1'b0;
        end

        // Clear beats a same-cycle error for the count; a new zero beats clear.
        err_cnt_d = clear_i ? {CNT_W{1'b0}} : cnt_nxt_s;
        zero_d    = (valid_i && is_zero_s) ? 1'b1 : (clear_i ? 1'b0 : zero_q);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SEEK;
            prev_q     <= {WIDTH{1'b0}};
            has_prev_q <= 1'b0;
            run_cnt_q  <= {RUN_W{1'b0}};
            miss_cnt_q <= {MISS_W{1'b0}};
            err_q      <= 1'b0;
            err_cnt_q  <= {CNT_W{1'b0}};
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            has_prev_q <= has_prev_d;
            run_cnt_q  <= run_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            zero_q     <= zero_d;
        end
    end

    assign locked_o  = (state_q == LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign zero_o    = zero_q;

endmodule
